// File: rtl/bram_ecc_scrubber.sv
// Background ECC scrubber for the 128-bit BRAM cache memory: reads each line in granted
// idle slots, writes back corrected single-bit errors and logs uncorrectable ones.
module bram_ecc_scrubber #(
   parameter int ADDRMSB    = 8,
   parameter int RD_LAT     = 2,
   parameter int INTERVAL_W = 16,
   parameter int CNT_W      = 16
) (
   input  logic                  gclk,
   input  logic                  rstn,
   input  logic                  en,
   input  logic [INTERVAL_W-1:0] interval,
   input  logic                  mem_gnt,
   input  logic                  fg_we,
   input  logic [ADDRMSB:0]      fg_addr,
   output logic                  mem_req,
   output logic [ADDRMSB:0]      mem_addr,
   output logic                  mem_we,
   output logic [127:0]          mem_wdata,
   input  logic [127:0]          mem_rdata,
   input  logic                  mem_sberr,
   input  logic                  mem_dberr,
   output logic [CNT_W-1:0]      sb_cnt,
   output logic [CNT_W-1:0]      db_cnt,
   output logic [ADDRMSB:0]      db_addr,
   output logic                  db_valid,
   input  logic                  clr,
   output logic                  pass_done
);

   // state  | meaning
   // IDLE   | inter-line gap, interval counter runs while en=1
   // RDREQ  | read of line ptr requested, waiting for mem_gnt
   // WAIT   | read latency; last cycle samples dout/flags (CHECK)
   // WRREQ  | write-back of corrected data, waiting for mem_gnt
   // ADV    | advance ptr, pulse pass_done on wrap, clear conflict

   localparam int AW    = ADDRMSB + 1;
   localparam int LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RDREQ = 3'd1,
      S_WAIT  = 3'd2,
      S_WRREQ = 3'd3,
      S_ADV   = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_next;
   logic [AW-1:0]         r_ptr;
   logic [INTERVAL_W-1:0] r_ivl_cnt;
   logic [LAT_W-1:0]      r_lat;
   logic                  r_conf;
   logic [127:0]          r_wdata;
   logic [CNT_W-1:0]      r_sb_cnt;
   logic [CNT_W-1:0]      r_db_cnt;
   logic [AW-1:0]         r_db_addr;
   logic                  r_db_valid;
   logic                  r_pass_done;

   logic w_fg_hit;
   logic w_sample;
   logic w_drop;
   logic w_ivl_hit;
   logic w_rd_gnt;

   assign w_fg_hit  = fg_we && (fg_addr == r_ptr);
   assign w_sample  = (r_state == S_WAIT) && (r_lat == LAT_W'(1));
   assign w_drop    = r_conf || w_fg_hit;
   assign w_ivl_hit = (r_ivl_cnt >= interval);
   assign w_rd_gnt  = (r_state == S_RDREQ) && en && mem_gnt;

   assign mem_addr  = r_ptr;
   assign mem_wdata = r_wdata;
   assign sb_cnt    = r_sb_cnt;
   assign db_cnt    = r_db_cnt;
   assign db_addr   = r_db_addr;
   assign db_valid  = r_db_valid;
   assign pass_done = r_pass_done;

   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next  = r_state;
      mem_req = 1'b0;
      mem_we  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (en && w_ivl_hit) w_next = S_RDREQ;
         end
         S_RDREQ: begin
            if (!en) begin
               w_next = S_IDLE;
            end else begin
               mem_req = 1'b1;
               if (mem_gnt) w_next = S_WAIT;
            end
         end
         S_WAIT: begin
            if (w_sample) begin
               if (mem_dberr)      w_next = S_ADV;
               else if (mem_sberr) w_next = S_WRREQ;
               else                w_next = S_ADV;
            end
         end
         // A foreground write to this line is newer than our corrected copy, so the request is withdrawn.
         S_WRREQ: begin
            if (w_drop) begin
               w_next = S_ADV;
            end else begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               if (mem_gnt) w_next = S_ADV;
            end
         end
         S_ADV:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge gclk or negedge rstn) begin
      if (!rstn) begin
         r_ptr       <= '0;
         r_ivl_cnt   <= '0;
         r_lat       <= '0;
         r_conf      <= 1'b0;
         r_wdata     <= '0;
         r_sb_cnt    <= '0;
         r_db_cnt    <= '0;
         r_db_addr   <= '0;
         r_db_valid  <= 1'b0;
         r_pass_done <= 1'b0;
      end else begin
         r_pass_done <= 1'b0;

         if ((r_state == S_IDLE) && en && !w_ivl_hit) r_ivl_cnt <= r_ivl_cnt + INTERVAL_W'(1);
         else                                          r_ivl_cnt <= '0;

         if (w_rd_gnt)                r_lat <= LAT_W'(RD_LAT);
         else if (r_state == S_WAIT)  r_lat <= r_lat - LAT_W'(1);

         if (r_state == S_ADV) begin
            r_conf <= 1'b0;
         end else if (w_fg_hit && (w_rd_gnt || (r_state == S_WAIT) || (r_state == S_WRREQ))) begin
            r_conf <= 1'b1;
         end

         if (w_sample && !mem_dberr && mem_sberr) r_wdata   <= mem_rdata;
         if (w_sample && mem_dberr)               r_db_addr <= r_ptr;

         // clr takes priority over a same-cycle error event; db_addr above still records it.
         if (clr) begin
            r_sb_cnt   <= '0;
            r_db_cnt   <= '0;
            r_db_valid <= 1'b0;
         end else if (w_sample) begin
            if (mem_dberr) begin
               if (r_db_cnt != {CNT_W{1'b1}}) r_db_cnt <= r_db_cnt + CNT_W'(1);
               r_db_valid <= 1'b1;
            end else if (mem_sberr) begin
               if (r_sb_cnt != {CNT_W{1'b1}}) r_sb_cnt <= r_sb_cnt + CNT_W'(1);
            end
         end

         if (r_state == S_ADV) begin
            r_ptr       <= r_ptr + AW'(1);
            r_pass_done <= &r_ptr;
         end
      end
   end

endmodule

// File: tb/tb_bram_ecc_scrubber.sv
// Scoreboard bench for bram_ecc_scrubber: a BRAM responder injects errors, an
// access-level model predicts the read/write stream and the error statistics.
`timescale 1ns/1ps
module tb_bram_ecc_scrubber;
   localparam int ADDRMSB = 8;
   localparam int RD_LAT  = 2;
   localparam int DEPTH   = 1 << (ADDRMSB + 1);

   logic          gclk = 1'b0;
   logic          rstn = 1'b1;
   logic          en = 1'b0;
   logic [15:0]   interval = '0;
   logic          mem_gnt = 1'b0;
   logic          fg_we = 1'b0;
   logic [8:0]    fg_addr = '0;
   logic          mem_req, mem_we;
   logic [8:0]    mem_addr;
   logic [127:0]  mem_wdata;
   logic [127:0]  mem_rdata = '0;
   logic          mem_sberr = 1'b0, mem_dberr = 1'b0;
   logic [15:0]   sb_cnt, db_cnt;
   logic [8:0]    db_addr;
   logic          db_valid, pass_done;
   logic          clr = 1'b0;

   // small saturation instance: every read reports an error
   logic          s_sberr = 1'b1, s_dberr = 1'b0;
   logic [127:0]  s_rdata = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   logic          s_mem_req, s_mem_we, s_db_valid, s_pass_done;
   logic [1:0]    s_mem_addr, s_db_addr, s_sb_cnt, s_db_cnt;
   logic [127:0]  s_mem_wdata;

   bram_ecc_scrubber #(.ADDRMSB(ADDRMSB), .RD_LAT(RD_LAT), .INTERVAL_W(16), .CNT_W(16)) dut (
      .gclk(gclk), .rstn(rstn), .en(en), .interval(interval), .mem_gnt(mem_gnt),
      .fg_we(fg_we), .fg_addr(fg_addr), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_sberr(mem_sberr), .mem_dberr(mem_dberr), .sb_cnt(sb_cnt), .db_cnt(db_cnt),
      .db_addr(db_addr), .db_valid(db_valid), .clr(clr), .pass_done(pass_done));

   bram_ecc_scrubber #(.ADDRMSB(1), .RD_LAT(RD_LAT), .INTERVAL_W(16), .CNT_W(2)) dut_sat (
      .gclk(gclk), .rstn(rstn), .en(1'b1), .interval(16'd0), .mem_gnt(1'b1),
      .fg_we(1'b0), .fg_addr(2'b00), .mem_req(s_mem_req), .mem_addr(s_mem_addr),
      .mem_we(s_mem_we), .mem_wdata(s_mem_wdata), .mem_rdata(s_rdata),
      .mem_sberr(s_sberr), .mem_dberr(s_dberr), .sb_cnt(s_sb_cnt), .db_cnt(s_db_cnt),
      .db_addr(s_db_addr), .db_valid(s_db_valid), .clr(1'b0), .pass_done(s_pass_done));

   always #5 gclk = ~gclk;

   typedef struct {
      bit           we;
      logic [8:0]   addr;
      logic [127:0] data;
      bit           chk_lat;
   } txn_t;

   txn_t         exp_q[$];
   int           checks = 0, errors = 0;
   int           inj_kind[DEPTH];   // 0 clean, 1 sberr, 2 dberr, 3 both flags
   bit           inj_conf[DEPTH];
   int           inj_dly[DEPTH];
   logic [127:0] inj_data[DEPTH];
   logic [127:0] mem_arr[DEPTH];

   int  ptr_m = 0, sb_m = 0, db_m = 0, dba_m = 0, pass_m = 0;
   bit  dbv_m = 0;
   int  gnt_mode = 0;               // 0 always, 1 random, 2 never, 3 reads only
   int  rd_target = 0, rd_granted = 0;
   int  pd_cnt = 0;
   bit  sat_bad = 0;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // One line of the scrub walk as seen from the memory port.
   task automatic plan_line(input int kind, input bit conf, input int dly, input logic [127:0] d);
      txn_t t;
      inj_kind[ptr_m] = kind;
      inj_conf[ptr_m] = conf;
      inj_dly[ptr_m]  = dly;
      inj_data[ptr_m] = d;
      t.we = 1'b0; t.addr = 9'(ptr_m); t.data = '0; t.chk_lat = 1'b0;
      exp_q.push_back(t);
      if (kind >= 2) begin
         if (db_m < 65535) db_m++;
         dba_m = ptr_m;
         dbv_m = 1'b1;
      end else if (kind == 1) begin
         if (sb_m < 65535) sb_m++;
         if (!conf) begin
            t.we = 1'b1; t.data = d; t.chk_lat = (gnt_mode == 0);
            exp_q.push_back(t);
         end
      end
      if (ptr_m == DEPTH - 1) pass_m++;
      ptr_m = (ptr_m + 1) % DEPTH;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((exp_q.size() != 0 || rd_granted < rd_target) && n < budget) begin
         @(negedge gclk);
         n++;
      end
      checks++;
      if (n >= budget) begin
         errors++;
         $display("FAIL drain_timeout: %0d expected accesses still pending after %0d cycles", exp_q.size(), n);
      end
      repeat (8) @(negedge gclk);
      #1;
   endtask

   // BRAM responder: grants, registered read data with error injection, foreground writes.
   initial begin : responder
      int cyc = 0, resp_due = -1, fg_due = -1, k;
      logic [8:0] resp_addr = '0, fg_a = '0;
      forever begin
         @(negedge gclk);
         cyc++;
         en = (rd_granted < rd_target);
         case (gnt_mode)
            0:       mem_gnt = 1'b1;
            1:       mem_gnt = ($urandom_range(0, 2) != 0);
            2:       mem_gnt = 1'b0;
            default: mem_gnt = !mem_we;
         endcase
         mem_rdata = '0; mem_sberr = 1'b0; mem_dberr = 1'b0;
         if (resp_due == cyc) begin
            k = inj_kind[resp_addr];
            mem_rdata = (k == 1 || k == 3) ? inj_data[resp_addr] : mem_arr[resp_addr];
            mem_sberr = (k == 1 || k == 3);
            mem_dberr = (k >= 2);
            inj_kind[resp_addr] = 0;
            inj_conf[resp_addr] = 1'b0;
            resp_due = -1;
         end
         if (rstn && mem_req && mem_gnt && !mem_we) begin
            rd_granted++;
            resp_due  = cyc + RD_LAT;
            resp_addr = mem_addr;
            if (inj_conf[mem_addr]) begin
               fg_due = cyc + inj_dly[mem_addr];
               fg_a   = mem_addr;
            end else if ($urandom_range(0, 3) == 0) begin
               fg_due = cyc + 1;
               fg_a   = mem_addr ^ 9'h1;
            end
         end
         fg_we = 1'b0;
         if (fg_due == cyc) begin
            fg_we   = 1'b1;
            fg_addr = fg_a;
            fg_due  = -1;
         end
      end
   end

   // Monitor: pops expectations whenever the port carries a granted access.
   initial begin : monitor
      txn_t e;
      int mcyc = 0, last_rd_cyc = 0, last_rd_addr = -1;
      logic [1:0] s_prev_sb = '0, s_prev_db = '0;
      forever begin
         @(negedge gclk);
         #1;
         mcyc++;
         if (mem_req && mem_gnt) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL txn_unexpected: got we=%0b addr=%0d, expected no access", mem_we, mem_addr);
            end else begin
               e = exp_q.pop_front();
               if (mem_we !== e.we || mem_addr !== e.addr || (e.we && mem_wdata !== e.data)) begin
                  errors++;
                  $display("FAIL txn: got we=%0b addr=%0d data=%h, expected we=%0b addr=%0d data=%h",
                           mem_we, mem_addr, mem_wdata, e.we, e.addr, e.data);
               end
               if (e.we && e.chk_lat) begin
                  checks++;
                  if (mcyc - last_rd_cyc != RD_LAT + 1) begin
                     errors++;
                     $display("FAIL wr_latency: got %0d cycles after read grant, expected %0d",
                              mcyc - last_rd_cyc, RD_LAT + 1);
                  end
               end
            end
            if (!mem_we) begin
               last_rd_cyc  = mcyc;
               last_rd_addr = int'(mem_addr);
            end
         end
         if (pass_done) begin
            pd_cnt++;
            checks++;
            if (last_rd_addr != DEPTH - 1) begin
               errors++;
               $display("FAIL pass_done_addr: pulse after read of %0d, expected after %0d", last_rd_addr, DEPTH - 1);
            end
         end
         if (rstn) begin
            if (s_sb_cnt < s_prev_sb || s_db_cnt < s_prev_db) sat_bad = 1'b1;
            if (s_mem_we && (!s_mem_req || s_mem_wdata !== s_rdata)) sat_bad = 1'b1;
            if (s_pass_done && s_mem_addr !== 2'd0) sat_bad = 1'b1;
         end
         s_prev_sb = s_sb_cnt;
         s_prev_db = s_db_cnt;
      end
   end

   initial begin : watchdog
      #600000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      int n, r, hold_addr;
      bit hold_bad;
      for (int i = 0; i < DEPTH; i++) begin
         mem_arr[i]  = rnd128();
         inj_kind[i] = 0;
         inj_conf[i] = 1'b0;
         inj_dly[i]  = 0;
         inj_data[i] = '0;
      end
      #1 rstn = 1'b0;
      repeat (3) @(negedge gclk);
      #1;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_wdata", mem_wdata, 0);
      chk("rst_sb_cnt", sb_cnt, 0);
      chk("rst_db_cnt", db_cnt, 0);
      chk("rst_db_addr", db_addr, 0);
      chk("rst_db_valid", db_valid, 0);
      chk("rst_pass_done", pass_done, 0);
      @(negedge gclk);
      rstn = 1'b1;

      // clean full pass, grants always available
      gnt_mode = 0; interval = 16'd0;
      for (int i = 0; i < DEPTH; i++) plan_line(0, 1'b0, 0, '0);
      rd_target += DEPTH;
      drain(8000);
      chk("clean_sb_cnt", sb_cnt, 0);
      chk("clean_db_cnt", db_cnt, 0);
      chk("clean_pass_done", pd_cnt, pass_m);

      // directed: conflict at 3, corrected write at 5, uncorrectable at 9
      for (int i = 0; i < 16; i++) begin
         if (i == 3)      plan_line(1, 1'b1, 1, rnd128());
         else if (i == 5) plan_line(1, 1'b0, 0, {16{8'hA5}});
         else if (i == 9) plan_line(2, 1'b0, 0, '0);
         else             plan_line(0, 1'b0, 0, '0);
      end
      rd_target += 16;
      drain(400);
      chk("dir_sb_cnt", sb_cnt, sb_m);
      chk("dir_db_cnt", db_cnt, db_m);
      chk("dir_db_addr", db_addr, 9);
      chk("dir_db_valid", db_valid, 1);
      @(negedge gclk); clr = 1'b1;
      @(negedge gclk); clr = 1'b0;
      #1;
      sb_m = 0; db_m = 0; dbv_m = 1'b0;
      chk("clr_db_valid", db_valid, 0);
      chk("clr_db_cnt", db_cnt, 0);
      chk("clr_sb_cnt", sb_cnt, 0);
      chk("clr_db_addr_kept", db_addr, 9);

      // randomized errors, conflicts, grants and interval
      gnt_mode = 1; interval = 16'($urandom_range(0, 3));
      for (int i = 0; i < 500; i++) begin
         r = $urandom_range(0, 19);
         case (r)
            0, 1:    plan_line(1, 1'b0, 0, rnd128());
            2:       plan_line(2, 1'b0, 0, '0);
            3:       plan_line(3, 1'b0, 0, rnd128());
            4:       plan_line(1, 1'b1, $urandom_range(0, 3), rnd128());
            default: plan_line(0, 1'b0, 0, '0);
         endcase
      end
      rd_target += 500;
      drain(30000);
      chk("rnd_sb_cnt", sb_cnt, sb_m);
      chk("rnd_db_cnt", db_cnt, db_m);
      chk("rnd_db_addr", db_addr, dba_m);
      chk("rnd_db_valid", db_valid, dbv_m);
      chk("rnd_pass_done", pd_cnt, pass_m);

      // grant withheld for 100 cycles in RDREQ
      gnt_mode = 2; interval = 16'd0;
      plan_line(0, 1'b0, 0, '0);
      rd_target += 1;
      n = 0;
      while (!mem_req && n < 20) begin
         @(negedge gclk); #1; n++;
      end
      chk("hold_req_seen", mem_req, 1);
      hold_addr = int'(mem_addr);
      hold_bad  = 1'b0;
      repeat (100) begin
         @(negedge gclk); #1;
         if (!mem_req || mem_we || int'(mem_addr) != hold_addr) hold_bad = 1'b1;
      end
      chk("hold_req_stable", hold_bad, 0);
      gnt_mode = 0;
      drain(100);

      // saturation on the small instance
      chk("sat_sb_cnt", s_sb_cnt, 3);
      chk("sat_db_cnt_zero", s_db_cnt, 0);
      s_dberr = 1'b1;
      repeat (80) @(negedge gclk);
      #1;
      chk("sat_db_cnt", s_db_cnt, 3);
      chk("sat_db_valid", s_db_valid, 1);
      chk("sat_sb_held", s_sb_cnt, 3);
      chk("sat_monotonic", sat_bad, 0);

      // async reset while a write-back waits for its grant
      gnt_mode = 3;
      plan_line(1, 1'b0, 0, rnd128());
      rd_target += 1;
      n = 0;
      while (!mem_we && n < 40) begin
         @(negedge gclk); #1; n++;
      end
      chk("wr_pending", mem_we, 1);
      repeat (3) @(negedge gclk);
      #1;
      chk("wr_still_pending", mem_we, 1);
      #1 rstn = 1'b0;
      #1;
      chk("arst_mem_we", mem_we, 0);
      chk("arst_mem_req", mem_req, 0);
      chk("arst_mem_addr", mem_addr, 0);
      chk("arst_mem_wdata", mem_wdata, 0);
      chk("arst_sb_cnt", sb_cnt, 0);
      chk("arst_db_valid", db_valid, 0);
      chk("arst_pending_write_only", exp_q.size(), 1);
      exp_q.delete();
      repeat (3) begin
         @(negedge gclk); #1;
         chk("arst_no_write", mem_we, 0);
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/bram_ecc_scrubber.md
Name: bram_ecc_scrubber

Overview:
- Background initiator for the 128-bit ECC-protected BRAM cache memory. That memory is the responder: 128-bit data, 16-bit ECC parity, per-read sberr/dberr flags, registered read output.
- Walks every line in idle slots granted by the pipeline. On a single-bit error it writes the corrected word back. On a double-bit error it logs the address.
- Sits between the cache pipeline's memory port mux and the BRAM. It reports error statistics to the debug/status registers.

Parameters:
- ADDRMSB, 8: memory address MSB; depth = 2^(ADDRMSB+1) lines.
- RD_LAT, 2: cycles from read address presented to dout/sberr/dberr valid (registered BRAM output).
- INTERVAL_W, 16: width of the inter-line scrub interval counter.
- CNT_W, 16: width of the saturating error counters.

Ports:
- gclk, in, 1: clock (memory clock domain).
- rstn, in, 1: asynchronous active-low reset.
- en, in, 1: scrubbing enable.
- interval, in, INTERVAL_W: idle cycles between line scrubs.
- mem_gnt, in, 1: pipeline grants the memory port to the scrubber this cycle.
- fg_we, in, 1: foreground (pipeline) write this cycle.
- fg_addr, in, ADDRMSB+1: foreground write address.
- mem_req, out, 1: scrubber requests the port.
- mem_addr, out, ADDRMSB+1: scrubber address.
- mem_we, out, 1: scrubber write enable; valid only with mem_gnt.
- mem_wdata, out, 128: corrected write-back data.
- mem_rdata, in, 128: memory read data.
- mem_sberr, in, 1: single-bit error flag for mem_rdata.
- mem_dberr, in, 1: double-bit error flag for mem_rdata.
- sb_cnt, out, CNT_W: corrected-error count, saturating.
- db_cnt, out, CNT_W: uncorrectable-error count, saturating.
- db_addr, out, ADDRMSB+1: address of the most recent double-bit error.
- db_valid, out, 1: sticky; set on dberr, cleared by clr.
- clr, in, 1: synchronous clear of sb_cnt, db_cnt and db_valid.
- pass_done, out, 1: one-cycle pulse when the last address is checked.

Behaviour:
- Reset values: state=IDLE, scrub pointer=0, interval counter=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, sb_cnt=0, db_cnt=0, db_addr=0, db_valid=0, pass_done=0.
- IDLE:
  - Counts up while en=1; holds at 0 while en=0.
  - When count >= interval (interval=0 means next cycle), go to RDREQ and clear the count.
- RDREQ:
  - mem_req=1, mem_we=0, mem_addr=ptr.
  - On mem_gnt=1, go to WAIT and load the latency counter with RD_LAT.
- WAIT:
  - Decrements the latency counter. Data is sampled in the cycle it reaches 0, i.e. exactly RD_LAT cycles after the granted read.
  - From the granted read cycle onward, any fg_we with fg_addr==ptr sets a local conflict flag.
- CHECK (same cycle as sample):
  - dberr: db_cnt+=1 (saturating), db_addr=ptr, db_valid=1, no write-back; go to ADV.
  - sberr and no dberr: sb_cnt+=1 (saturating), latch mem_rdata into mem_wdata; go to WRREQ.
  - Neither flag: go to ADV.
- WRREQ:
  - mem_req=1, mem_we=1, mem_addr=ptr. The memory re-encodes ECC on write.
  - Write completes on the cycle mem_gnt=1, then go to ADV.
  - If the conflict flag is set, or a fg_we to ptr occurs in the same cycle, drop the write and go to ADV. Newer foreground data wins.
- ADV:
  - ptr+=1, wrapping from 2^(ADDRMSB+1)-1 to 0; the wrap asserts pass_done for 1 cycle.
  - Clears the conflict flag; return to IDLE.
- mem_req is asserted only in RDREQ and WRREQ. mem_we=0 outside WRREQ.
- The scrubber never drives a write without mem_gnt. The pipeline may withhold mem_gnt indefinitely; the scrubber waits without timeout.
- en deasserted:
  - In IDLE or RDREQ: return to IDLE, drop mem_req, ptr unchanged.
  - In WAIT, CHECK or WRREQ: complete the current line first.
- Counters stop at 2^CNT_W-1.
- clr and a same-cycle error event: clr wins for the counters and db_valid. db_addr still updates.
- Async reset mid-operation aborts immediately to reset values. No write is issued after rstn falls.

Test Plan:
- Clean memory, interval=0, mem_gnt=1 always, depth 512 -> 512 reads with no writes; pass_done pulses once after address 511; sb_cnt=db_cnt=0; next read at address 0.
- Inject sberr at address 5 with rdata=0xA5..A5 -> exactly one write to address 5 with that data, RD_LAT+1 cycles after the read grant; sb_cnt=1.
- Inject dberr at address 9 -> no write; db_cnt=1, db_addr=9, db_valid=1; clr the next cycle -> db_valid=0, db_cnt=0, db_addr stays 9.
- sberr at address 3 with fg_we to address 3 one cycle after the read grant -> write-back suppressed; sb_cnt=1; ptr advances to 4.
- mem_gnt held low for 100 cycles in RDREQ, then pulsed -> mem_req stays high throughout; a single read is issued; mem_addr is stable the whole time.
- Force sb_cnt to 0xFFFF and inject sberr -> sb_cnt stays 0xFFFF. Assert rstn=0 during WRREQ -> mem_we drops immediately and all outputs reach reset values.
